video_frame_monitor: RTL and testbench

Synthesizable, parametrised per-frame monitor for a parallel video stream (DE/HS/VS plus N colour channels) running in the pixel clock domain. It measures each frame's timing (total/active line length, total/active line count) and computes a CRC-32 over all active pixels. Each completed frame is reported to a consumer through a valid/ready interface. It sits alongside the HDMI output of the display system: in simulation, and on FPGA for self-checking against golden frame signatures.

---
 rtl/video_mon_pkg.sv | 49 ++++
 rtl/video_crc32.sv | 53 +++++
 rtl/video_frame_monitor.sv | 260 ++++++++++++++++++++++++++
 tb/tb_video_frame_monitor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_mon_pkg
//  Purpose  : Shared definitions for the video frame monitor. Contents:
//             - CRC-32 constants and the parallel CRC update function
//             - the capture state enum
//             - the fixed-width part of a frame report
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package video_mon_pkg;

   localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
   // Widest pixel word the CRC helper accepts.
   localparam int          MAX_PIX_W = 64;

   typedef enum logic [0:0] {
      WAIT_SYNC = 1'b0,
      CAPTURE   = 1'b1
   } mon_state_t;

   // Width-independent report fields. The timing counters depend on the
   // module's counter width and are grouped in a struct local to the top.
   typedef struct packed {
      logic [31:0] frame_idx;
      logic [31:0] crc;
      logic        line_len_err;
   } frame_report_t;

   // MSB-first CRC-32 over the low pix_w bits of data: bit pix_w-1 enters
   // first. No reflection and no final XOR.
   function automatic logic [31:0] crc32_upd(input logic [31:0]          crc,
                                             input logic [MAX_PIX_W-1:0] data,
                                             input int                   pix_w);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = MAX_PIX_W - 1; i >= 0; i--) begin
         if (i < pix_w) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
         end
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/video_crc32.sv
`default_nettype none
// ============================================================================
//  Module   : video_crc32
//  Purpose  : CRC-32 register consuming one PixW-bit word per enabled clock.
//  Ports    : clk   - clock
//             rst_n - asynchronous active-low reset (register clears to 0)
//             init  - restart from the CRC seed this cycle
//             en    - fold data into the CRC this cycle (after init, if both)
//             data  - PixW-bit word, MSB consumed first
//             crc   - current CRC value
//  Revision : 1.0 - initial release
// ============================================================================
module video_crc32
   import video_mon_pkg::*;
#(
   parameter int PixW = 24
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            init,
   input  logic            en,
   input  logic [PixW-1:0] data,
   output logic [31:0]     crc
);

   logic [31:0]          crc_q;
   logic [31:0]          seed;
   logic [31:0]          crc_d;
   logic [MAX_PIX_W-1:0] data_ext;

   always_comb begin
      data_ext            = '0;
      data_ext[PixW-1:0]  = data;
   end

   // init and en together start a fresh CRC that already includes this word.
   always_comb begin
      seed  = init ? CRC_INIT : crc_q;
      crc_d = en ? crc32_upd(seed, data_ext, PixW) : seed;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= '0;
      end else if (init || en) begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/video_frame_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : video_frame_monitor
//  Purpose  : Per-frame timing measurement and active-pixel CRC-32 for a
//             DE/HS/VS parallel video stream. Each completed frame is
//             offered on a valid/ready report port.
//  Ports    : clk_hdmi_i / rst_hdmi_ni  - pixel clock, async active-low reset
//             clear_i                   - synchronous soft clear
//             vs_pol_i, hs_pol_i        - sync polarity (1 = active-high)
//             de_i, hs_i, vs_i, pixel_i - video input (channel 0 in LSBs)
//             report_valid_o / report_ready_i - report handshake
//             frame_idx_o, h_total_o, h_active_o, v_total_o, v_active_o,
//             crc_o, line_len_err_o     - report fields
//             drop_cnt_o                - saturating count of dropped reports
//  Revision : 1.0 - initial release
// ============================================================================
module video_frame_monitor
   import video_mon_pkg::*;
#(
   parameter int ChannelWidth = 8,
   parameter int NumChannels  = 3,
   parameter int CntWidth     = 12,
   parameter int DropCntWidth = 8
) (
   input  logic                                clk_hdmi_i,
   input  logic                                rst_hdmi_ni,
   input  logic                                clear_i,
   input  logic                                vs_pol_i,
   input  logic                                hs_pol_i,
   input  logic                                de_i,
   input  logic                                hs_i,
   input  logic                                vs_i,
   input  logic [NumChannels*ChannelWidth-1:0] pixel_i,
   output logic                                report_valid_o,
   input  logic                                report_ready_i,
   output logic [31:0]                         frame_idx_o,
   output logic [CntWidth-1:0]                 h_total_o,
   output logic [CntWidth-1:0]                 h_active_o,
   output logic [CntWidth-1:0]                 v_total_o,
   output logic [CntWidth-1:0]                 v_active_o,
   output logic [31:0]                         crc_o,
   output logic                                line_len_err_o,
   output logic [DropCntWidth-1:0]             drop_cnt_o
);

   localparam int PixW = NumChannels * ChannelWidth;

   typedef struct packed {
      logic [CntWidth-1:0] h_total;
      logic [CntWidth-1:0] h_active;
      logic [CntWidth-1:0] v_total;
      logic [CntWidth-1:0] v_active;
   } timing_t;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return (&v) ? v : v + CntWidth'(1);
   endfunction

   // ------------------------------------------------------------------
   // Event detection against the previous cycle (syncs normalised so
   // that 1 always means "pulse active")
   // ------------------------------------------------------------------
   logic vs_act, hs_act;
   logic vs_q, hs_q, de_q;
   logic frame_edge, line_edge, run_start, run_end;

   assign vs_act = ~(vs_i ^ vs_pol_i);
   assign hs_act = ~(hs_i ^ hs_pol_i);

   always_ff @(posedge clk_hdmi_i or negedge rst_hdmi_ni) begin
      if (!rst_hdmi_ni) begin
         vs_q <= 1'b0;
         hs_q <= 1'b0;
         de_q <= 1'b0;
      end else begin
         vs_q <= vs_act;
         hs_q <= hs_act;
         de_q <= de_i;
      end
   end

   assign frame_edge = vs_q & ~vs_act;
   assign line_edge  = hs_q & ~hs_act;
   assign run_start  = de_i & ~de_q;
   assign run_end    = de_q & ~de_i;

   // ------------------------------------------------------------------
   // Capture FSM and report load/drop decision
   // ------------------------------------------------------------------
   mon_state_t state_q, state_d;
   logic       valid_q;
   logic       close_frame, load_rpt, drop_rpt;

   always_ff @(posedge clk_hdmi_i or negedge rst_hdmi_ni) begin
      if (!rst_hdmi_ni) begin
         state_q <= WAIT_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      close_frame = 1'b0;
      load_rpt    = 1'b0;
      drop_rpt    = 1'b0;
      if (clear_i) begin
         state_d = WAIT_SYNC;
      end else if (frame_edge) begin
         state_d = CAPTURE;
         // The edge seen in WAIT_SYNC only arms capture; the partial frame
         // before it is never reported.
         if (state_q == CAPTURE) begin
            close_frame = 1'b1;
            if (!valid_q || report_ready_i) begin
               load_rpt = 1'b1;
            end else begin
               drop_rpt = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame accumulators
   // ------------------------------------------------------------------
   logic [CntWidth-1:0] hcnt, vcnt, runlen, h_total, h_active, v_active;
   logic                have_first, err;

   // Closing-frame view: register contents plus any line edge or run end
   // detected this cycle, since those complete activity from last cycle.
   logic [CntWidth-1:0] cl_h_total, cl_v_total, cl_h_active;
   logic                cl_err, cl_have_first;

   always_comb begin
      cl_h_total    = line_edge ? sat_inc(hcnt) : h_total;
      cl_v_total    = line_edge ? sat_inc(vcnt) : vcnt;
      cl_h_active   = h_active;
      cl_err        = err;
      cl_have_first = have_first | run_end;
      if (run_end) begin
         if (!have_first) begin
            cl_h_active = runlen;
         end else if (runlen != h_active) begin
            cl_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_hdmi_i or negedge rst_hdmi_ni) begin
      if (!rst_hdmi_ni) begin
         hcnt       <= '0;
         vcnt       <= '0;
         runlen     <= '0;
         h_total    <= '0;
         h_active   <= '0;
         v_active   <= '0;
         have_first <= 1'b0;
         err        <= 1'b0;
      end else if (clear_i) begin
         hcnt       <= '0;
         vcnt       <= '0;
         runlen     <= '0;
         h_total    <= '0;
         h_active   <= '0;
         v_active   <= '0;
         have_first <= 1'b0;
         err        <= 1'b0;
      end else if (frame_edge) begin
         // DE sampled on the edge cycle already belongs to the new frame.
         hcnt       <= '0;
         vcnt       <= '0;
         h_total    <= '0;
         h_active   <= '0;
         have_first <= 1'b0;
         err        <= 1'b0;
         runlen     <= de_i ? CntWidth'(1) : '0;
         v_active   <= run_start ? CntWidth'(1) : '0;
      end else begin
         // hcnt counts cycles after the line edge, so period = hcnt + 1.
         hcnt       <= line_edge ? '0 : sat_inc(hcnt);
         vcnt       <= cl_v_total;
         h_total    <= cl_h_total;
         h_active   <= cl_h_active;
         have_first <= cl_have_first;
         err        <= cl_err;
         if (de_i) begin
            runlen <= run_start ? CntWidth'(1) : sat_inc(runlen);
         end
         if (run_start) begin
            v_active <= sat_inc(v_active);
         end
      end
   end

   // CRC restarts on the edge cycle and takes that cycle's pixel if DE is high.
   logic [31:0] crc_cur;

   video_crc32 #(
      .PixW (PixW)
   ) u_crc (
      .clk   (clk_hdmi_i),
      .rst_n (rst_hdmi_ni),
      .init  (clear_i | frame_edge),
      .en    (de_i & ~clear_i),
      .data  (pixel_i),
      .crc   (crc_cur)
   );

   // ------------------------------------------------------------------
   // Report register, frame index and drop counter
   // ------------------------------------------------------------------
   frame_report_t           rpt_q;
   timing_t                 tim_q;
   logic [31:0]             idx_cnt;
   logic [DropCntWidth-1:0] drop_q;

   always_ff @(posedge clk_hdmi_i or negedge rst_hdmi_ni) begin
      if (!rst_hdmi_ni) begin
         valid_q <= 1'b0;
         rpt_q   <= '0;
         tim_q   <= '0;
         idx_cnt <= '0;
         drop_q  <= '0;
      end else if (clear_i) begin
         // Drop statistics survive a soft clear.
         valid_q <= 1'b0;
         idx_cnt <= '0;
      end else begin
         if (load_rpt) begin
            valid_q <= 1'b1;
            rpt_q   <= '{frame_idx: idx_cnt, crc: crc_cur, line_len_err: cl_err};
            tim_q   <= '{h_total:  cl_h_total,
                         h_active: cl_h_active,
                         v_total:  cl_v_total,
                         v_active: v_active};
         end else if (valid_q && report_ready_i) begin
            valid_q <= 1'b0;
         end
         if (close_frame && !(&idx_cnt)) begin
            idx_cnt <= idx_cnt + 32'd1;
         end
         if (drop_rpt && !(&drop_q)) begin
            drop_q <= drop_q + DropCntWidth'(1);
         end
      end
   end

   assign report_valid_o = valid_q;
   assign frame_idx_o    = rpt_q.frame_idx;
   assign crc_o          = rpt_q.crc;
   assign line_len_err_o = rpt_q.line_len_err;
   assign h_total_o      = tim_q.h_total;
   assign h_active_o     = tim_q.h_active;
   assign v_total_o      = tim_q.v_total;
   assign v_active_o     = tim_q.v_active;
   assign drop_cnt_o     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_video_frame_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_frame_monitor
//  Purpose  : Self-checking bench for video_frame_monitor. A frame generator
//             builds the expected report for each frame it sends; a monitor
//             pops and compares a report on every valid/ready transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_frame_monitor;

   localparam int PW   = 24;
   localparam int CNTW = 12;
   localparam int DW   = 8;

   logic            clk     = 1'b0;
   logic            rst_n   = 1'b0;
   logic            clear   = 1'b0;
   logic            vs_pol  = 1'b1;
   logic            hs_pol  = 1'b1;
   logic            de      = 1'b0;
   logic            hs      = 1'b0;
   logic            vs      = 1'b0;
   logic [PW-1:0]   pixel   = '0;
   logic            ready   = 1'b1;

   logic            report_valid;
   logic [31:0]     frame_idx;
   logic [CNTW-1:0] h_total, h_active, v_total, v_active;
   logic [31:0]     crc;
   logic            line_len_err;
   logic [DW-1:0]   drop_cnt;

   always #5 clk = ~clk;

   video_frame_monitor #(
      .ChannelWidth (8),
      .NumChannels  (3),
      .CntWidth     (CNTW),
      .DropCntWidth (DW)
   ) dut (
      .clk_hdmi_i     (clk),
      .rst_hdmi_ni    (rst_n),
      .clear_i        (clear),
      .vs_pol_i       (vs_pol),
      .hs_pol_i       (hs_pol),
      .de_i           (de),
      .hs_i           (hs),
      .vs_i           (vs),
      .pixel_i        (pixel),
      .report_valid_o (report_valid),
      .report_ready_i (ready),
      .frame_idx_o    (frame_idx),
      .h_total_o      (h_total),
      .h_active_o     (h_active),
      .v_total_o      (v_total),
      .v_active_o     (v_active),
      .crc_o          (crc),
      .line_len_err_o (line_len_err),
      .drop_cnt_o     (drop_cnt)
   );

   typedef struct {
      logic [31:0] idx;
      logic [31:0] crc;
      int          ht;
      int          ha;
      int          vt;
      int          va;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bit-serial reference CRC-32 (poly 04C11DB7, MSB first).
   function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [PW-1:0] d);
      logic [31:0] r;
      r = c;
      for (int b = PW - 1; b >= 0; b--) begin
         if (r[31] ^ d[b]) r = (r << 1) ^ 32'h04C1_1DB7;
         else              r = r << 1;
      end
      return r;
   endfunction

   // Report monitor: a transfer is valid & ready at the next rising edge.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && report_valid && ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_report", 64'(frame_idx), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = sb_q.pop_front();
            chk("rpt_idx",      64'(frame_idx),    64'(e.idx));
            chk("rpt_crc",      64'(crc),          64'(e.crc));
            chk("rpt_h_total",  64'(h_total),      64'(e.ht));
            chk("rpt_h_active", 64'(h_active),     64'(e.ha));
            chk("rpt_v_total",  64'(v_total),      64'(e.vt));
            chk("rpt_v_active", 64'(v_active),     64'(e.va));
            chk("rpt_err",      64'(line_len_err), 64'(e.err));
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      clear = 1'b0;
      de    = 1'b0;
      vs    = ~vs_pol;
      hs    = ~hs_pol;
      pixel = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One frame: line 0 carries the VS pulse, each line has a 2-cycle HS
   // pulse at x=0..1 and DE from x=2 on lines 2..2+nact-1 (5 cycles on
   // bad_line, else 4). The frame edge is line 1, x=0.
   // exp_v/exp_idx: expected valid/index one cycle after the edge (-1 skip).
   task automatic send_frame(input int htot, input int vtot, input int nact,
                             input int bad_line, input bit pix_rand,
                             input int exp_v, input int exp_idx,
                             input bit rdy_edge, input int clr_line,
                             output exp_t e);
      logic [31:0] c;
      int          first;
      logic        err;
      int          len;
      c     = 32'hFFFF_FFFF;
      first = -1;
      err   = 1'b0;
      for (int l = 0; l < vtot; l++) begin
         for (int x = 0; x < htot; x++) begin
            @(posedge clk);
            #1;
            len   = (l == bad_line) ? 5 : 4;
            vs    = (l == 0) ? vs_pol : ~vs_pol;
            hs    = (x < 2) ? hs_pol : ~hs_pol;
            de    = (l >= 2) && (l < 2 + nact) && (x >= 2) && (x < 2 + len);
            pixel = pix_rand ? PW'($urandom) : '0;
            if (de) c = model_crc(c, pixel);
            if ((l >= 2) && (l < 2 + nact) && (x == 2)) begin
               if (first < 0)        first = len;
               else if (len != first) err = 1'b1;
            end
            if (rdy_edge && l == 1) ready = (x == 0);
            if (l == clr_line)      clear = (x == 3);
            if (l == clr_line && x == 4) begin
               @(negedge clk);
               chk("valid_after_clear", 64'(report_valid), 64'd0);
            end
            if (l == 1 && x == 1 && exp_v >= 0) begin
               @(negedge clk);
               chk("valid_after_edge", 64'(report_valid), 64'(exp_v));
               if (exp_idx >= 0) chk("idx_after_edge", 64'(frame_idx), 64'(exp_idx));
            end
         end
      end
      e.idx = 32'd0;
      e.crc = c;
      e.ht  = (htot > 4095) ? 4095 : htot;
      e.ha  = (first < 0) ? 0 : first;
      e.vt  = vtot;
      e.va  = nact;
      e.err = err;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      exp_t e;

      // ---------------- reset state ----------------
      do_reset();
      @(negedge clk);
      chk("rst_valid", 64'(report_valid), 64'd0);
      chk("rst_idx",   64'(frame_idx),    64'd0);
      chk("rst_crc",   64'(crc),          64'd0);
      chk("rst_drop",  64'(drop_cnt),     64'd0);
      chk("rst_htot",  64'(h_total),      64'd0);
      chk("rst_vact",  64'(v_active),     64'd0);
      chk("rst_err",   64'(line_len_err), 64'd0);

      // ---------------- basic frame ----------------
      ready = 1'b1;
      send_frame(10, 6, 3, -1, 1'b0, 0, -1, 1'b0, -1, e);
      e.idx = 32'd0; sb_q.push_back(e);
      send_frame(10, 6, 3, -1, 1'b0, 1, 0, 1'b0, -1, e);
      e.idx = 32'd1; sb_q.push_back(e);
      send_frame(10, 6, 3, -1, 1'b0, 1, 1, 1'b0, -1, e);

      // ---------------- inverted polarity ----------------
      vs_pol = 1'b0;
      hs_pol = 1'b0;
      do_reset();
      send_frame(10, 6, 3, -1, 1'b0, 0, -1, 1'b0, -1, e);
      e.idx = 32'd0; sb_q.push_back(e);
      send_frame(10, 6, 3, -1, 1'b0, 1, 0, 1'b0, -1, e);
      vs_pol = 1'b1;
      hs_pol = 1'b1;

      // ---------------- uneven line, then clean frame ----------------
      do_reset();
      send_frame(10, 6, 3, 3, 1'b1, 0, -1, 1'b0, -1, e);
      e.idx = 32'd0; sb_q.push_back(e);
      send_frame(12, 7, 4, -1, 1'b1, 1, 0, 1'b0, -1, e);
      e.idx = 32'd1; sb_q.push_back(e);
      send_frame(10, 6, 3, -1, 1'b1, 1, 1, 1'b0, -1, e);

      // ---------------- backpressure ----------------
      do_reset();
      ready = 1'b0;
      send_frame(10, 6, 3, -1, 1'b1, 0, -1, 1'b0, -1, e);
      e.idx = 32'd0; sb_q.push_back(e);
      send_frame(10, 6, 2, -1, 1'b1, 1, 0, 1'b0, -1, e);
      send_frame(10, 6, 3, -1, 1'b1, 1, 0, 1'b0, -1, e);
      @(negedge clk);
      chk("bp_drop1", 64'(drop_cnt), 64'd1);
      send_frame(10, 6, 1, -1, 1'b1, 1, 0, 1'b0, -1, e);
      @(negedge clk);
      chk("bp_drop2", 64'(drop_cnt),  64'd2);
      chk("bp_kept",  64'(frame_idx), 64'd0);
      e.idx = 32'd3; sb_q.push_back(e);
      fork
         send_frame(10, 6, 3, -1, 1'b1, 1, 3, 1'b0, -1, e);
         begin
            repeat (3) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
            @(negedge clk);
            chk("bp_valid_drop", 64'(report_valid), 64'd0);
         end
      join
      // Ready only on the edge cycle: idx 3 transfers and idx 4 loads.
      begin
         exp_t e4;
         e4 = e;
         send_frame(10, 6, 3, -1, 1'b1, 1, 4, 1'b1, -1, e);
         @(negedge clk);
         chk("bp_edge_drop", 64'(drop_cnt), 64'd2);
         chk("bp_edge_crc",  64'(crc),      64'(e4.crc));
         chk("bp_edge_vact", 64'(v_active), 64'(e4.va));
      end

      // ---------------- async reset mid-frame ----------------
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(report_valid), 64'd0);
      chk("arst_drop",  64'(drop_cnt),     64'd0);
      chk("arst_idx",   64'(frame_idx),    64'd0);
      chk("arst_crc",   64'(crc),          64'd0);
      chk("arst_htot",  64'(h_total),      64'd0);

      // ---------------- counter saturation ----------------
      do_reset();
      ready = 1'b1;
      send_frame(5000, 3, 1, -1, 1'b1, 0, -1, 1'b0, -1, e);
      e.idx = 32'd0; sb_q.push_back(e);
      send_frame(10, 3, 0, -1, 1'b1, 1, 0, 1'b0, -1, e);

      // ---------------- soft clear with pending report ----------------
      do_reset();
      ready = 1'b0;
      send_frame(10, 6, 3, -1, 1'b1, 0, -1, 1'b0, -1, e);
      send_frame(10, 6, 3, -1, 1'b1, 1, 0, 1'b0, 3, e);
      send_frame(10, 6, 2, -1, 1'b1, 0, -1, 1'b0, -1, e);
      e.idx = 32'd0; sb_q.push_back(e);
      send_frame(10, 6, 3, -1, 1'b1, 1, 0, 1'b0, -1, e);
      @(posedge clk);
      #1 ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("clr_drained", 64'(report_valid), 64'd0);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
